// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: glyph patterns (active-low gfedcba), scan
// FSM states and anode-select helpers. The display encoder uses the same table.
package sevenseg_pkg;

  localparam logic [6:0] Glyph0     = 7'h40;
  localparam logic [6:0] Glyph1     = 7'h79;
  localparam logic [6:0] Glyph2     = 7'h24;
  localparam logic [6:0] Glyph3     = 7'h30;
  localparam logic [6:0] Glyph4     = 7'h19;
  localparam logic [6:0] Glyph5     = 7'h12;
  localparam logic [6:0] Glyph6     = 7'h02;
  localparam logic [6:0] Glyph7     = 7'h78;
  localparam logic [6:0] Glyph8     = 7'h00;
  localparam logic [6:0] Glyph9     = 7'h10;
  localparam logic [6:0] GlyphA     = 7'h08;
  localparam logic [6:0] GlyphB     = 7'h03;
  localparam logic [6:0] GlyphC     = 7'h46;
  localparam logic [6:0] GlyphD     = 7'h21;
  localparam logic [6:0] GlyphE     = 7'h06;
  localparam logic [6:0] GlyphF     = 7'h0E;
  localparam logic [6:0] GlyphBlank = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } scan_state_e;

  // True when exactly one bit is set; applied to the inverted anode vector.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the set bit of a one-hot vector.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Scan bus (anodes/segments) plus the recovered-frame outputs.
interface sevenseg_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_ok;
  logic [3:0]  digit_blank;
  logic        frame_valid;
  logic        scan_err;
  logic        stale;

  // Display driver side: drives the scan bus, observes decoded results.
  modport master (
    output an, seg,
    input  digits, digit_ok, digit_blank, frame_valid, scan_err, stale
  );

  // Decoder side.
  modport slave (
    input  an, seg,
    output digits, digit_ok, digit_blank, frame_valid, scan_err, stale
  );
endinterface

// File: rtl/sevenseg_glyph_decode.sv
// Combinational segment-pattern to hex-nibble decoder.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       ok_o,
  output logic       blank_o
);

  // Table lookup; unknown and blank patterns decode to nibble 0.
  always_comb begin
    nibble_o = 4'h0;
    ok_o     = 1'b0;
    blank_o  = (seg_i == GlyphBlank);
    case (seg_i)
      Glyph0:  {ok_o, nibble_o} = {1'b1, 4'h0};
      Glyph1:  {ok_o, nibble_o} = {1'b1, 4'h1};
      Glyph2:  {ok_o, nibble_o} = {1'b1, 4'h2};
      Glyph3:  {ok_o, nibble_o} = {1'b1, 4'h3};
      Glyph4:  {ok_o, nibble_o} = {1'b1, 4'h4};
      Glyph5:  {ok_o, nibble_o} = {1'b1, 4'h5};
      Glyph6:  {ok_o, nibble_o} = {1'b1, 4'h6};
      Glyph7:  {ok_o, nibble_o} = {1'b1, 4'h7};
      Glyph8:  {ok_o, nibble_o} = {1'b1, 4'h8};
      Glyph9:  {ok_o, nibble_o} = {1'b1, 4'h9};
      GlyphA:  {ok_o, nibble_o} = {1'b1, 4'hA};
      GlyphB:  {ok_o, nibble_o} = {1'b1, 4'hB};
      GlyphC:  {ok_o, nibble_o} = {1'b1, 4'hC};
      GlyphD:  {ok_o, nibble_o} = {1'b1, 4'hD};
      GlyphE:  {ok_o, nibble_o} = {1'b1, 4'hE};
      GlyphF:  {ok_o, nibble_o} = {1'b1, 4'hF};
      default: {ok_o, nibble_o} = {1'b0, 4'h0};
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers hex digits from a 4-digit multiplexed seven-segment scan bus and
// assembles them into complete frames with per-digit validity.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input logic                    clock,
  input logic                    reset_n,
  sevenseg_scan_decoder_if.slave bus
);

  localparam int unsigned CntW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]  SettleMax  = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [IdleW-1:0] IdleMax    = IdleW'(TIMEOUT_CYCLES);

  // {an, seg}: s1 is the first sync stage, smp_q the usable sample.
  logic [10:0] smp_s1_q, smp_q, smp_prev_q;
  logic        sample_changed, one_low, multi_low;
  logic [3:0]  an_low;
  logic [1:0]  slot;

  logic [CntW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  scan_state_e      state_q, state_d;
  logic             capture;

  logic [3:0]       dec_nibble;
  logic             dec_ok, dec_blank;

  logic [3:0][3:0]  shadow_digits_q, shadow_digits_d;
  logic [3:0]       shadow_ok_q, shadow_ok_d, shadow_blank_q, shadow_blank_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  digits_q, digits_d;
  logic [3:0]       ok_q, ok_d, blank_q, blank_d;
  logic             frame_valid_q, frame_valid_d;
  logic             scan_err_q, scan_err_d;
  logic             stale_q, stale_d;

  // Two-flop synchronizer plus previous-sample register; idles as a dark bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      smp_s1_q   <= '1;
      smp_q      <= '1;
      smp_prev_q <= '1;
    end else begin
      smp_s1_q   <= {bus.an, bus.seg};
      smp_q      <= smp_s1_q;
      smp_prev_q <= smp_q;
    end
  end

  assign sample_changed = (smp_q != smp_prev_q);
  assign an_low         = ~smp_q[10:7];
  assign one_low        = is_onehot(an_low);
  assign multi_low      = (an_low != 4'd0) && !one_low;
  assign slot           = onehot_index(an_low);

  sevenseg_glyph_decode u_decode (
    .seg_i    (smp_q[6:0]),
    .nibble_o (dec_nibble),
    .ok_o     (dec_ok),
    .blank_o  (dec_blank)
  );

  // Settle counter: restarts on any sample change, saturates at SETTLE_CYCLES.
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    if (sample_changed)                settle_cnt_d = '0;
    else if (settle_cnt_q != SettleMax) settle_cnt_d = settle_cnt_q + 1'b1;
  end

  // Scan FSM; saturation makes capture and scan_err fire once per stable run.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    scan_err_d = 1'b0;
    if (sample_changed) begin
      state_d = one_low ? StSettle : StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (one_low) state_d = StSettle;
          else if (multi_low && settle_cnt_d == SettleLast) scan_err_d = 1'b1;
        end
        StSettle: begin
          if (settle_cnt_d == SettleLast) begin
            capture = 1'b1;
            state_d = StHold;
          end
        end
        StHold:  state_d = StHold;
        default: state_d = StIdle;
      endcase
    end
  end

  // Shadow capture and frame publication; a capture on the publish edge
  // lands in the next frame.
  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_ok_d     = shadow_ok_q;
    shadow_blank_d  = shadow_blank_q;
    mask_d          = mask_q;
    digits_d        = digits_q;
    ok_d            = ok_q;
    blank_d         = blank_q;
    frame_valid_d   = 1'b0;
    if (mask_q == 4'hF) begin
      digits_d      = shadow_digits_q;
      ok_d          = shadow_ok_q;
      blank_d       = shadow_blank_q;
      frame_valid_d = 1'b1;
      mask_d        = 4'h0;
    end
    if (capture) begin
      shadow_digits_d[slot] = dec_nibble;
      shadow_ok_d[slot]     = dec_ok;
      shadow_blank_d[slot]  = dec_blank;
      mask_d[slot]          = 1'b1;
    end
  end

  // Idle timeout: counts cycles since the last capture.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (capture)                    idle_cnt_d = '0;
    else if (idle_cnt_q != IdleMax) idle_cnt_d = idle_cnt_q + 1'b1;
    stale_d = !capture && (idle_cnt_d == IdleMax);
  end

  // State, counters, shadow and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      settle_cnt_q    <= '0;
      idle_cnt_q      <= '0;
      shadow_digits_q <= '0;
      shadow_ok_q     <= '0;
      shadow_blank_q  <= '0;
      mask_q          <= '0;
      digits_q        <= '0;
      ok_q            <= '0;
      blank_q         <= '0;
      frame_valid_q   <= 1'b0;
      scan_err_q      <= 1'b0;
      stale_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      settle_cnt_q    <= settle_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_ok_q     <= shadow_ok_d;
      shadow_blank_q  <= shadow_blank_d;
      mask_q          <= mask_d;
      digits_q        <= digits_d;
      ok_q            <= ok_d;
      blank_q         <= blank_d;
      frame_valid_q   <= frame_valid_d;
      scan_err_q      <= scan_err_d;
      stale_q         <= stale_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_ok    = ok_q;
  assign bus.digit_blank = blank_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.scan_err    = scan_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed seven-segment display drivers: watches a 4-digit time-multiplexed anode/segment bus and recovers the displayed hex nibbles.
- Drives self-checking display benches and board loopback diagnostics. Example: Pmod header wired back to FPGA inputs.
- Filters scan transitions, decodes segment patterns to nibbles, and assembles complete 4-digit frames with per-digit validity.

Parameters:
- SETTLE_CYCLES, 16: consecutive identical synchronized samples required before a digit is accepted. Legal range 2..65535.
- TIMEOUT_CYCLES, 1048576: cycles without an accepted digit before stale asserts. Legal range ≥ SETTLE_CYCLES.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset; the only reset
- an  in  4  anode enables, active-low; an[i]=0 selects digit i
- seg  in  7  segment cathodes, active-low; bit0=a … bit6=g
- digits  out  16  last complete frame; digits[4i+3:4i] = digit i
- digit_ok  out  4  per-digit: pattern was a legal hex glyph in last frame
- digit_blank  out  4  per-digit: pattern was 7'h7F (all off) in last frame
- frame_valid  out  1  one-cycle pulse when digits/digit_ok/digit_blank update
- scan_err  out  1  one-cycle pulse when a stable sample has more than one anode low
- stale  out  1  level: no digit accepted for TIMEOUT_CYCLES cycles

Behaviour:
- Reset (async assert, sync release) clears all of the following: digits=0, digit_ok=0, digit_blank=0, frame_valid=0, scan_err=0, stale=0, capture mask=0, counters=0, FSM=IDLE.
- Input path: an and seg each pass through a 2-flop synchronizer. The sample is the 11-bit value {an,seg} after the synchronizer.
- Settle counter: resets to 0 whenever the sample differs from the previous sample; otherwise increments and saturates at SETTLE_CYCLES.
- FSM states:
  - IDLE: no anode, or multiple anodes low.
  - SETTLE: exactly one anode low; counting.
  - HOLD: digit accepted; wait for the sample to change.
- FSM transitions:
  - IDLE→SETTLE: on a sample with exactly one anode low.
  - SETTLE→HOLD: when the counter reaches SETTLE_CYCLES-1 with the sample unchanged; the digit is captured on that edge.
  - SETTLE/HOLD→IDLE or SETTLE (restart): on any sample change.
  - Multiple-low sample: if stable for SETTLE_CYCLES, emit one scan_err pulse, stay IDLE, wait for change.
- Capture latency: an input held from before edge t is captured at edge t+1+SETTLE_CYCLES.
- Decode, captured into slot i of the shadow register (sets mask[i]):
  - Glyph table, active-low gfedcba: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - 7F: nibble 0, ok=0, blank=1.
  - Any other pattern: nibble 0, ok=0, blank=0.
- Recapture of a slot before the frame completes overwrites it; mask is unchanged.
- Frame: on the edge after mask becomes 4'b1111:
  - shadow copies to the outputs;
  - frame_valid pulses for 1 cycle;
  - mask clears.
- A capture on that same edge goes into the new frame's shadow.
- Stale: the idle counter resets on every capture. stale sets when the count reaches TIMEOUT_CYCLES, and clears on the next capture.
- Reset mid-frame discards the partial shadow.

Decomposition:
- Shared package sevenseg_pkg holds:
  - the 16 glyph constants and the BLANK constant (7'h7F);
  - the FSM state enum;
  - the one-hot validity function.
  The display encoder uses the same package.
- One sub-module: sevenseg_glyph_decode. It is combinational: 7-bit pattern → {nibble, ok, blank}.

Test Plan:
- Scan digits 3,0,1,2 on anodes 0..3 at 64 cycles each, SETTLE_CYCLES=16 → frame_valid pulses once; digits=16'h2103; digit_ok=4'hF; digit_blank=0.
- Drive an=4'b1110, seg=7'h30 for exactly 15 cycles, then change → no capture, no frame. Hold the same value for 16 cycles → slot 0 captured exactly 17 edges after the drive.
- Anode 2 shows 7'h7F and anode 3 shows 7'h55; others show 'A' → digit_blank=4'b0100; digit_ok=4'b0011; digits=16'h00AA.
- Hold an=4'b1100 for 40 cycles → exactly one scan_err pulse; no capture; mask unchanged.
- Run a continuous scan, then stop (an=4'hF) for TIMEOUT_CYCLES → stale=1 exactly TIMEOUT_CYCLES cycles after the last capture. Resume the scan → stale clears on the first capture.
- Assert reset_n=0 asynchronously after 3 of 4 digits → all outputs 0 immediately. After release, a full new scan is needed for frame_valid; old slots are not reused.
